// File: rtl/uart_tx_if.sv
// Word-in handshake between the UART producer and the transmit control FSM.
// The producer owns data/valid/parity controls; the FSM owns ready.
interface uart_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;
  logic              par_en;
  logic              par_type;

  modport master (
    output data_in,
    output data_valid,
    output par_en,
    output par_type,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    input  par_en,
    input  par_type,
    output data_ready
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit control FSM: latches a word, sequences start/data/parity/stop
// bits onto tx_out and drives the external bit counter and baud generator enable.
module uart_tx_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 3
) (
    input  logic             clk,
    input  logic             hard_rst,
    uart_tx_if.slave         req,
    input  logic             baud_tick,
    output logic             baud_en,
    input  logic [CNT_W-1:0] bit_cnt,
    output logic             cnt_clr,
    output logic             cnt_incr,
    output logic             tx_out,
    output logic             busy,
    output logic             tx_done
);

    // The counter must be able to index every data bit and wrap exactly at the last one.
    if (DATA_W != (1 << CNT_W)) begin : g_width_check
        $error("uart_tx_ctrl: DATA_W must equal 2**CNT_W");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] data_q;
    logic              par_q;
    logic              par_en_q;
    logic              accept;
    logic              last_bit;

    assign last_bit = (bit_cnt == CNT_W'(DATA_W - 1));
    assign accept   = (state == S_IDLE) && req.data_valid;

    // Moore outputs
    assign req.data_ready = (state == S_IDLE);
    assign busy           = (state != S_IDLE);
    assign baud_en        = (state != S_IDLE);
    assign cnt_clr        = (state == S_IDLE) || (state == S_START);

    always_ff @(posedge clk or posedge hard_rst) begin
        if (hard_rst) begin
            state    <= S_IDLE;
            data_q   <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            state   <= state_nxt;
            tx_done <= (state == S_STOP) && baud_tick;
            if (accept) begin
                data_q   <= req.data_in;
                par_en_q <= req.par_en;
                par_q    <= (^req.data_in) ^ req.par_type;
            end
        end
    end

    // tx_out depends only on registered state plus the counter value, never on baud_tick.
    always_comb begin
        state_nxt = state;
        cnt_incr  = 1'b0;
        tx_out    = 1'b1;
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_START;
            end
            S_START: begin
                tx_out = 1'b0;
                if (baud_tick) state_nxt = S_DATA;
            end
            S_DATA: begin
                tx_out = data_q[bit_cnt];
                if (baud_tick) begin
                    if (!last_bit) cnt_incr = 1'b1;
                    else if (par_en_q) state_nxt = S_PARITY;
                    else state_nxt = S_STOP;
                end
            end
            S_PARITY: begin
                tx_out = par_q;
                if (baud_tick) state_nxt = S_STOP;
            end
            S_STOP: begin
                if (baud_tick) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
